calc_7seg_param: RTL
====================

// Module: calc_7seg_param
// PURPOSE
//  Parametrised successor to the 4-bit calculator/7-seg block. It takes WIDTH-bit
//  operands and an 8-opcode ALU, including a multi-cycle shift-add multiply.
//  A start/busy/done handshake launches each operation.
//  The registered 2*WIDTH-bit result is shown in hex on a time-multiplexed,
//  active-low NUM_DIGITS x 7-seg display.
//  The block sits between board switches/buttons and the display pins.
// PARAMETERS
//  WIDTH        8       operand width; legal range 4..16
//  NUM_DIGITS   8       number of display digits; 4*NUM_DIGITS >= 2*WIDTH required
//  REFRESH_DIV  100000  clk cycles per digit dwell; >=2 (use 4 in simulation)
// PORTS
//  clk       in   1             single system clock, rising edge
//  rst_n     in   1             asynchronous reset, active-low
//  start     in   1             launch request, sampled only in IDLE
//  OP        in   3             opcode, latched with start
//  A         in   WIDTH         operand A, latched with start
//  B         in   WIDTH         operand B, latched with start
//  busy      out  1             operation in progress
//  done      out  1             one-cycle pulse when result/flags update
//  cout      out  1             carry flag (see BEHAVIOUR)
//  ovf       out  1             overflow flag (see BEHAVIOUR)
//  inv_leds  out  7             segments, active-low; bit0=a .. bit6=g
//  enb_leds  out  NUM_DIGITS    digit enables, active-low one-hot
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - FSM=IDLE; result=0; busy=done=cout=ovf=0; digit index=0; prescaler=0.
//   - enb_leds=~1 (digit 0 on); inv_leds=7'b1000000 ("0").
//   - Reset asserted mid-MUL aborts the multiply; no done pulse.
//  Opcodes
//   - 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR; 101 MUL; 110 SHL A by B[3:0];
//     111 SHR (logical) A by B[3:0].
//   - Non-MUL results are zero-extended to 2*WIDTH bits.
//  FSM states: IDLE -> EXEC -> DONE -> IDLE
//   - IDLE: start=1 at edge k latches OP/A/B; busy=1 from edge k.
//   - EXEC, non-MUL: one cycle. Result and flags load at edge k+1, with done=1.
//   - EXEC, MUL: one shift-add step per cycle for WIDTH cycles.
//     Result loads at edge k+WIDTH, with done=1.
//   - DONE: lasts exactly one cycle. busy=0 and done=0 at the next edge.
//     A start during that edge is ignored; the block is back in IDLE the cycle after.
//   - start while busy is ignored, and does not queue.
//  Flags (held with result until the next done)
//   - ADD: cout = carry out of bit WIDTH-1; ovf = signed two's-complement overflow.
//   - SUB: computed as A+~B+1. cout=1 means no borrow (A>=B unsigned);
//     ovf = signed overflow.
//   - MUL: cout=0; ovf=1 iff result[2*WIDTH-1:WIDTH] != 0.
//   - Logic and shift ops: cout=0, ovf=0.
//  Display scan
//   - Prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0, and the
//     digit index increments, wrapping from NUM_DIGITS-1 to 0.
//   - Digit i shows nibble result[4i+3:4i], or 0 above bit 2*WIDTH-1.
//   - Segment pattern: 0-9, A, b, C, d, E, F.
//   - Outputs are registered. inv_leds/enb_leds change in the same cycle as the
//     index, so no ghosting.
//   - A result update takes effect on the currently lit digit at the next edge.
//     The scan is never reset by an operation.
// STRUCTURE
//  - Shared package (calc_pkg): OP_* opcode localparams, FSM state encodings,
//    and the 16-entry hex-to-segment table.
//  - One sub-module, hex7seg: 4-bit nibble -> 7-bit active-high segments
//    (combinational). The top inverts its output.
//  - The top holds the FSM, operand/result registers, multiplier datapath,
//    prescaler and scan counter.
// TESTING  (WIDTH=8, NUM_DIGITS=8, REFRESH_DIV=4)
//  1. OP=ADD, A=3, B=2, start pulse
//     -> done exactly 1 cycle later; result=16'h0005; cout=0; ovf=0.
//  2. OP=ADD, A=8'h7F, B=8'h01 -> result=16'h0080; ovf=1; cout=0.
//     Then OP=ADD, A=8'hFF, B=8'h01 -> result=16'h0000; cout=1; ovf=0.
//  3. OP=SUB, A=8, B=9 -> result=16'h00FF; cout=0; ovf=0.
//     Then OP=SUB, A=8'h80, B=1 -> result=16'h007F; cout=1; ovf=1.
//  4. OP=MUL, A=8'hFF, B=8'hFF -> busy for 8 cycles; done at start+8;
//     result=16'hFE01; ovf=1.
//     A second start pulsed at start+3 is ignored, and the result is unchanged.
//  5. Scan, with result 16'h00A1 -> enb_leds steps ~8'h01, ~8'h02 ... ~8'h80, ~8'h01,
//     one step every 4 cycles.
//     Digit 0 shows 7'b1111001 ("1"); digit 1 shows 7'b0001000 ("A");
//     digits 2..7 show 7'b1000000 ("0").
//  6. Drop rst_n mid-MUL at start+4 -> all outputs at reset values
//     asynchronously; no done pulse.
//     After release, a fresh ADD 1+1 gives result=16'h0002.

Source files
------------

// File: rtl/calc_7seg_param_pkg.sv
// Shared definitions for the parametrised calculator / 7-segment block:
// opcodes, FSM state encoding and the hex-to-segment table.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-high segments, bit0=a .. bit6=g; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/calc_7seg_param_if.sv
// Operand/handshake/flag bundle between the board controls and the calculator.
interface calc_7seg_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             cout;
    logic             ovf;

    modport master (output start, OP, A, B, input busy, done, cout, ovf);
    modport slave  (input start, OP, A, B, output busy, done, cout, ovf);
endinterface

// File: rtl/calc_7seg_param_hex7seg.sv
// Combinational nibble to active-high 7-segment decoder.
module hex7seg
    import calc_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/calc_7seg_param.sv
// WIDTH-bit 8-opcode calculator with start/busy/done handshake; the registered
// 2*WIDTH-bit result is scanned in hex onto an active-low multiplexed display.
module calc_7seg_param
    import calc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    calc_7seg_param_if.slave      bus,
    output logic [6:0]            inv_leds,
    output logic [NUM_DIGITS-1:0] enb_leds
);

    localparam int RES_W   = 2 * WIDTH;
    localparam int CNT_W   = $clog2(WIDTH) + 1;
    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("calc_7seg_param: WIDTH must be 4..16");
    end
    if (4 * NUM_DIGITS < RES_W) begin : g_bad_digits
        $error("calc_7seg_param: too few digits for the result");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("calc_7seg_param: REFRESH_DIV must be at least 2");
    end

    // ---------------- operation FSM and datapath ----------------
    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [RES_W-1:0]   r_mcand;
    logic [RES_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [RES_W-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_cout;
    logic               w_alu_ovf;
    logic [RES_W-1:0]   w_acc_step;
    logic               w_mul_last;

    always_comb begin
        w_sum      = '0;
        w_alu_res  = '0;
        w_alu_cout = 1'b0;
        w_alu_ovf  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum      = {1'b0, r_a} + {1'b0, r_b};
                w_alu_res  = w_sum[WIDTH-1:0];
                w_alu_cout = w_sum[WIDTH];
                w_alu_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                w_sum      = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
                w_alu_res  = w_sum[WIDTH-1:0];
                w_alu_cout = w_sum[WIDTH];
                w_alu_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_XOR:  w_alu_res = r_a ^ r_b;
            OP_SHL:  w_alu_res = r_a << r_b[3:0];
            OP_SHR:  w_alu_res = r_a >> r_b[3:0];
            default: w_alu_res = '0;
        endcase
    end

    // One shift-add step: r_b is consumed LSB first while r_mcand walks left.
    assign w_acc_step = r_acc + (r_b[0] ? r_mcand : {RES_W{1'b0}});
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.OP;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_mcand <= {{WIDTH{1'b0}}, bus.A};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_acc   <= w_acc_step;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_mul_last) begin
                            r_result <= w_acc_step;
                            r_cout   <= 1'b0;
                            r_ovf    <= |w_acc_step[RES_W-1:WIDTH];
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else begin
                        r_result <= {{WIDTH{1'b0}}, w_alu_res};
                        r_cout   <= w_alu_cout;
                        r_ovf    <= w_alu_ovf;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

    // ---------------- display scan ----------------
    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_inv_leds;
    logic [NUM_DIGITS-1:0]   r_enb_leds;

    logic                    w_presc_tc;
    logic [PRESC_W-1:0]      w_presc_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [4*NUM_DIGITS-1:0] w_padded;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [3:0]              w_nib_sel;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_enb_next;

    assign w_presc_tc   = (r_presc == PRESC_W'(REFRESH_DIV - 1));
    assign w_presc_next = w_presc_tc ? '0 : r_presc + 1'b1;
    assign w_idx_next   = !w_presc_tc ? r_idx :
                          (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

    // Digits above the result width read as zero.
    assign w_padded = (4 * NUM_DIGITS)'(r_result);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_nib[gi]      = w_padded[4*gi +: 4];
        assign w_enb_next[gi] = (w_idx_next != IDX_W'(gi));
    end

    // Segments are looked up for the next index so they move with the enables.
    assign w_nib_sel = w_nib[w_idx_next];

    hex7seg u_hex7seg (
        .i_nibble (w_nib_sel),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_inv_leds <= 7'b1000000;
            r_enb_leds <= ~NUM_DIGITS'(1);
        end else begin
            r_presc    <= w_presc_next;
            r_idx      <= w_idx_next;
            r_inv_leds <= ~w_seg;
            r_enb_leds <= w_enb_next;
        end
    end

    assign inv_leds = r_inv_leds;
    assign enb_leds = r_enb_leds;

endmodule
